aes_encryption: RTL and testbench

AES_ENCRYPTION -- requirements
Module: aes_encryption

---
 rtl/aes_encryption.sv | 176 +++++++++++++++++
 tb/tb_aes_encryption.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encryption.sv
// Iterative AES-128 encryptor: one round per clock, external round-key source, stallable output.
// Optional one-entry input buffer compiled in with `define AES_ENC_SKID_EN.
module aes_encryption (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         read_fifo,
    input  logic         is_full,
    input  logic [127:0] fifo_in,
    input  logic [127:0] round_key_input,
    input  logic [127:0] round_key_10,
    output logic [3:0]   round_key_addr,
    output logic [127:0] data_output,
    output logic         data_done,
    output logic         data_valid
);

    localparam int unsigned BLK_W      = 128;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned LAST_ROUND = 9;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, HOLD} fsm_t;

    fsm_t             fsm;
    logic [CNT_W-1:0] rnd;
    logic [BLK_W-1:0] state_q;
    logic [BLK_W-1:0] round_c;
    logic [BLK_W-1:0] final_c;
    logic             start_c;
    logic [BLK_W-1:0] start_blk_c;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (a^254) followed by the affine transform
    function automatic logic [7:0] sub_byte(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] b;
        r = a;
        for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
        b = gf_mul(r, r);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Byte i of the block is bits [127-8i -: 8]; column c holds bytes 4c..4c+3
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic mix);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   mc [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) sb[i] = sub_byte(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4*c+r] = sb[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            if (mix) begin
                mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end else begin
                mc[4*c]   = a0;
                mc[4*c+1] = a1;
                mc[4*c+2] = a2;
                mc[4*c+3] = a3;
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = mc[i];
        return o ^ k;
    endfunction

    always_comb begin
        round_c = aes_round(state_q, round_key_input, 1'b1);
        final_c = aes_round(state_q, round_key_10, 1'b0);
    end

`ifdef AES_ENC_SKID_EN
    logic             buf_full;
    logic [BLK_W-1:0] buf_data;

    // A buffered block takes priority over a fresh strobe once back in IDLE
    assign start_c     = (fsm == IDLE) && (read_fifo || buf_full);
    assign start_blk_c = buf_full ? buf_data : fifo_in;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (fsm == IDLE) begin
            buf_full <= 1'b0;
        end else if (read_fifo && !buf_full) begin
            buf_full <= 1'b1;
            buf_data <= fifo_in;
        end
    end
`else
    assign start_c     = (fsm == IDLE) && read_fifo;
    assign start_blk_c = fifo_in;
`endif

    // Control FSM; round_key_addr tracks the round counter during ROUND and is 0 elsewhere
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fsm            <= IDLE;
            rnd            <= '0;
            state_q        <= '0;
            round_key_addr <= '0;
            data_output    <= '0;
            data_done      <= 1'b0;
            data_valid     <= 1'b0;
        end else begin
            data_done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start_c) begin
                        state_q        <= start_blk_c ^ round_key_input;
                        rnd            <= CNT_W'(1);
                        round_key_addr <= CNT_W'(1);
                        data_valid     <= 1'b0;
                        fsm            <= ROUND;
                    end
                end
                ROUND: begin
                    state_q <= round_c;
                    if (rnd == CNT_W'(LAST_ROUND)) begin
                        rnd            <= '0;
                        round_key_addr <= '0;
                        fsm            <= FINAL;
                    end else begin
                        rnd            <= rnd + CNT_W'(1);
                        round_key_addr <= rnd + CNT_W'(1);
                    end
                end
                FINAL: begin
                    if (!is_full) begin
                        data_output <= final_c;
                        data_done   <= 1'b1;
                        data_valid  <= 1'b1;
                        fsm         <= IDLE;
                    end else begin
                        state_q <= final_c;
                        fsm     <= HOLD;
                    end
                end
                HOLD: begin
                    if (!is_full) begin
                        data_output <= state_q;
                        data_done   <= 1'b1;
                        data_valid  <= 1'b1;
                        fsm         <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encryption.sv
// Self-checking bench for aes_encryption: transaction-level AES model plus FIPS-197 vectors.
module tb_aes_encryption;

    logic         tb_clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         read_fifo = 1'b0;
    logic         is_full = 1'b0;
    logic [127:0] fifo_in = '0;
    logic [127:0] round_key_input;
    logic [127:0] round_key_10;
    logic [3:0]   round_key_addr;
    logic [127:0] data_output;
    logic         data_done;
    logic         data_valid;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] rk [11];

    aes_encryption dut (
        .clk             (tb_clk),
        .n_rst           (n_rst),
        .read_fifo       (read_fifo),
        .is_full         (is_full),
        .fifo_in         (fifo_in),
        .round_key_input (round_key_input),
        .round_key_10    (round_key_10),
        .round_key_addr  (round_key_addr),
        .data_output     (data_output),
        .data_done       (data_done),
        .data_valid      (data_valid)
    );

    always #5 tb_clk = ~tb_clk;

    // Key generator stand-in: combinational lookup of the expanded schedule
    assign round_key_input = (round_key_addr <= 4'd9) ? rk[round_key_addr] : '0;
    assign round_key_10    = rk[10];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 0; x = a; y = b;
        while (y != 0) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box by brute-force inverse search and bitwise affine formula
    task automatic build_sbox();
        logic [7:0] inv, s, c63;
        c63 = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
            sbox_t[x] = s;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Reference cipher on a [row][col] state matrix using the current schedule
    function automatic logic [127:0] aes_ref(input logic [127:0] pt);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] o;
        coef[0] = 8'd2; coef[1] = 8'd3; coef[2] = 8'd1; coef[3] = 8'd1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(4*c+r) -: 8] ^ rk[0][127-8*(4*c+r) -: 8];
        for (int n = 1; n <= 10; n++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox_t[s[r][(c+r)%4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    acc = 0;
                    if (n < 10) for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k-r+4)%4], t[k][c]);
                    else acc = t[r][c];
                    s[r][c] = acc ^ rk[n][127-8*(4*c+r) -: 8];
                end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[r][c];
        return o;
    endfunction

    // Transaction model: m_age = edges since accept (-1 idle, 10 stalled after final round)
    int           m_age = -1;
    logic [127:0] m_ct = '0;
    logic [127:0] exp_out = '0;
    logic         exp_done = 1'b0;
    logic         exp_valid = 1'b0;
    logic [3:0]   exp_addr = '0;
    logic [127:0] skq [$];
    logic         m_start;
    logic [127:0] m_blk;
    int           done_cnt = 0;

    always @(posedge tb_clk or negedge n_rst) begin
        if (!n_rst) begin
            m_age = -1; exp_out = '0; exp_done = 1'b0; exp_valid = 1'b0; exp_addr = '0;
            skq.delete();
        end else begin
            exp_done = 1'b0;
            if (m_age == -1) begin
                m_start = read_fifo;
                m_blk   = fifo_in;
`ifdef AES_ENC_SKID_EN
                if (skq.size() > 0) begin
                    m_start = 1'b1;
                    m_blk   = skq.pop_front();
                end
`endif
                if (m_start) begin
                    m_ct = aes_ref(m_blk);
                    exp_valid = 1'b0;
                    m_age = 0;
                end
            end else begin
`ifdef AES_ENC_SKID_EN
                if (read_fifo && skq.size() == 0) skq.push_back(fifo_in);
`endif
                if (m_age < 9) m_age++;
                else if (!is_full) begin
                    exp_out = m_ct; exp_done = 1'b1; exp_valid = 1'b1; m_age = -1;
                end else m_age = 10;
            end
            exp_addr = (m_age >= 0 && m_age <= 8) ? 4'(m_age + 1) : 4'd0;
        end
    end

    // Cycle compare against the model, away from the active edge
    always @(posedge tb_clk) begin
        #1;
        if (n_rst) begin
            chk("cyc_addr", 128'(round_key_addr), 128'(exp_addr));
            chk("cyc_done", 128'(data_done), 128'(exp_done));
            chk("cyc_valid", 128'(data_valid), 128'(exp_valid));
            chk("cyc_data", data_output, exp_out);
            if (data_done) done_cnt++;
        end
    end

    task automatic run_block(input logic [127:0] pt, input int hold, output int lat,
                             output logic [39:0] addr_seq);
        @(negedge tb_clk);
        read_fifo = 1'b1;
        fifo_in   = pt;
        addr_seq  = {36'b0, round_key_addr};
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge tb_clk); #1;
            read_fifo = 1'b0;
            if (i <= 9) addr_seq = {addr_seq[35:0], round_key_addr};
            if (hold > 0 && i == 10) is_full = 1'b1;
            if (hold > 0 && i == 10 + hold) is_full = 1'b0;
            if (data_done) begin
                lat = i;
                break;
            end
        end
        is_full = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_age != -1 || skq.size() != 0 || read_fifo) && n < 100) begin
            @(negedge tb_clk);
            n++;
        end
        chk("idle_wait", 128'(n < 100), 128'(1));
    endtask

    initial begin
        int           lat;
        int           d0;
        logic [39:0]  aseq;
        logic [127:0] pa, pb, pc, exp_last;

        build_sbox();
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("ref_fips_b", aes_ref(128'h3243f6a8885a308d313198a2e0370734),
            128'h3925841d02dc09fbdc118597196a0b32);
        repeat (3) @(negedge tb_clk);
        chk("rst_data", data_output, '0);
        chk("rst_done", 128'(data_done), '0);
        chk("rst_valid", 128'(data_valid), '0);
        chk("rst_addr", 128'(round_key_addr), '0);
        n_rst = 1'b1;
        repeat (2) @(negedge tb_clk);

        run_block(128'h3243f6a8885a308d313198a2e0370734, 0, lat, aseq);
        chk("fips_b_latency", 128'(lat), 128'(11));
        chk("fips_b_data", data_output, 128'h3925841d02dc09fbdc118597196a0b32);
        @(posedge tb_clk); #1;
        chk("fips_b_pulse_len", 128'(data_done), '0);

        wait_idle();
        expand(128'h000102030405060708090a0b0c0d0e0f);
        chk("ref_fips_c", aes_ref(128'h00112233445566778899aabbccddeeff),
            128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        run_block(128'h00112233445566778899aabbccddeeff, 0, lat, aseq);
        chk("fips_c_data", data_output, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("fips_c_addr_seq", 128'(aseq), 128'(40'h0123456789));

        wait_idle();
        run_block(128'h00112233445566778899aabbccddeeff, 5, lat, aseq);
        chk("hold_latency", 128'(lat), 128'(16));
        chk("hold_data", data_output, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // Reset mid-operation, then a fresh block
        wait_idle();
        @(negedge tb_clk);
        read_fifo = 1'b1;
        fifo_in = 128'h3243f6a8885a308d313198a2e0370734;
        repeat (5) begin @(posedge tb_clk); #1; read_fifo = 1'b0; end
        chk("mid_addr_r5", 128'(round_key_addr), 128'(5));
        @(negedge tb_clk);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_data", data_output, '0);
        chk("mid_rst_done", 128'(data_done), '0);
        chk("mid_rst_valid", 128'(data_valid), '0);
        chk("mid_rst_addr", 128'(round_key_addr), '0);
        @(negedge tb_clk);
        n_rst = 1'b1;
        run_block(128'h00112233445566778899aabbccddeeff, 0, lat, aseq);
        chk("post_rst_latency", 128'(lat), 128'(11));
        chk("post_rst_data", data_output, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // Extra strobes during rounds 3 and 5
        wait_idle();
        pa = 128'h00112233445566778899aabbccddeeff;
        pb = {$urandom, $urandom, $urandom, $urandom};
        pc = {$urandom, $urandom, $urandom, $urandom};
        d0 = done_cnt;
        @(negedge tb_clk);
        read_fifo = 1'b1;
        fifo_in = pa;
        for (int i = 1; i <= 40; i++) begin
            @(posedge tb_clk); #1;
            read_fifo = 1'b0;
            if (i == 4) begin read_fifo = 1'b1; fifo_in = pb; end
            if (i == 6) begin read_fifo = 1'b1; fifo_in = pc; end
        end
        @(negedge tb_clk);
`ifdef AES_ENC_SKID_EN
        exp_last = aes_ref(pb);
        chk("strobe_done_count", 128'(done_cnt - d0), 128'(2));
`else
        exp_last = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        chk("strobe_done_count", 128'(done_cnt - d0), 128'(1));
`endif
        chk("strobe_last_data", data_output, exp_last);

        // Randomized blocks, stalls and stray strobes
        for (int it = 0; it < 25; it++) begin
            wait_idle();
            @(negedge tb_clk);
            expand({$urandom, $urandom, $urandom, $urandom});
            d0 = done_cnt;
            read_fifo = 1'b1;
            fifo_in = {$urandom, $urandom, $urandom, $urandom};
            for (int c = 0; c < 30; c++) begin
                @(negedge tb_clk);
                is_full   = ($urandom_range(0, 3) == 0);
                read_fifo = ($urandom_range(0, 7) == 0);
                fifo_in   = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge tb_clk);
            is_full = 1'b0;
            read_fifo = 1'b0;
            wait_idle();
            chk("rand_some_done", 128'(done_cnt > d0), 128'(1));
        end

        repeat (3) @(negedge tb_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
